// File: rtl/qblock_manager.sv
// qblock_manager: item-box controller. Tests car positions against fixed block
// hit boxes, arbitrates collisions, grants pseudo-random items and runs each
// block's respawn cooldown.
module qblock_manager #(
  parameter int NUM_BLOCKS     = 4,
  parameter int NUM_CARS       = 2,
  parameter int COORD_WIDTH    = 12,
  // block 3..0 x: 0, 688, -235, -707
  parameter logic [NUM_BLOCKS*COORD_WIDTH-1:0] BLOCK_X = {12'h000, 12'h2B0, 12'hF15, 12'hD3D},
  // block 3..0 y: -308, 0, -155, 0
  parameter logic [NUM_BLOCKS*COORD_WIDTH-1:0] BLOCK_Y = {12'hECC, 12'h000, 12'hF65, 12'h000},
  parameter int HIT_RADIUS     = 24,
  parameter int REGEN_INTERVAL = 10,
  parameter int REGEN_WIDTH    = 4,
  parameter int ITEM_WIDTH     = 2
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_clear,
  input  logic                              i_sec_tick,
  input  logic                              i_pos_valid,
  input  logic [NUM_CARS*COORD_WIDTH-1:0]   i_car_x,
  input  logic [NUM_CARS*COORD_WIDTH-1:0]   i_car_y,
  input  logic [NUM_CARS-1:0]               i_car_holding,
  output logic [NUM_BLOCKS-1:0]             o_block_active,
  output logic [NUM_CARS-1:0]               o_grant_valid,
  output logic [NUM_CARS*ITEM_WIDTH-1:0]    o_grant_item,
  output logic [NUM_CARS*3-1:0]             o_grant_block
);

  localparam int              DW        = COORD_WIDTH + 1;
  localparam int              RRW       = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
  localparam logic [DW-1:0]   RADIUS    = DW'(HIT_RADIUS);
  localparam logic [15:0]     LFSR_SEED = 16'hACE1;
  localparam logic [15:0]     LFSR_TAPS = 16'hB400;

  typedef enum logic {ST_ACTIVE, ST_COOLDOWN} blk_state_t;

  blk_state_t                          state_q [NUM_BLOCKS];
  blk_state_t                          state_d [NUM_BLOCKS];
  logic [REGEN_WIDTH-1:0]              cnt_q   [NUM_BLOCKS];
  logic [REGEN_WIDTH-1:0]              cnt_d   [NUM_BLOCKS];
  logic [NUM_CARS-1:0][NUM_BLOCKS-1:0] hit_d;
  logic [NUM_CARS-1:0][NUM_BLOCKS-1:0] hit_q;
  logic [NUM_CARS-1:0][NUM_BLOCKS-1:0] req;
  logic [NUM_BLOCKS-1:0]               granted;
  logic                                v_q;
  logic [RRW-1:0]                      rr_q;
  logic [RRW-1:0]                      rr_d;
  logic [15:0]                         lfsr_q;
  logic [NUM_CARS-1:0]                 gv_d;
  logic [NUM_CARS*ITEM_WIDTH-1:0]      gi_d;
  logic [NUM_CARS*3-1:0]               gb_d;

  // |car - blk| < radius, evaluated one bit wider so extremes cannot overflow
  function automatic logic in_box(input logic signed [COORD_WIDTH-1:0] car,
                                  input logic signed [COORD_WIDTH-1:0] blk);
    logic signed [DW-1:0] diff;
    logic [DW-1:0]        mag;
    diff = DW'(car) - DW'(blk);
    mag  = diff[DW-1] ? $unsigned(-diff) : $unsigned(diff);
    return mag < RADIUS;
  endfunction

  // Stage 1 combinational hit matrix for every car/block pair
  always_comb begin
    hit_d = '0;
    for (int unsigned c = 0; c < NUM_CARS; c++) begin
      for (int unsigned b = 0; b < NUM_BLOCKS; b++) begin
        hit_d[c][b] = in_box(i_car_x[c*COORD_WIDTH +: COORD_WIDTH], BLOCK_X[b*COORD_WIDTH +: COORD_WIDTH])
                    & in_box(i_car_y[c*COORD_WIDTH +: COORD_WIDTH], BLOCK_Y[b*COORD_WIDTH +: COORD_WIDTH]);
      end
    end
  end

  // Stage 2 request: mask by live state and holding, keep each car's lowest block
  always_comb begin
    req = '0;
    for (int unsigned c = 0; c < NUM_CARS; c++) begin
      for (int unsigned b = 0; b < NUM_BLOCKS; b++) begin
        if (v_q && !i_clear && !i_car_holding[c] && state_q[b] == ST_ACTIVE
            && hit_q[c][b] && req[c] == '0) begin
          req[c][b] = 1'b1;
        end
      end
    end
  end

  // Per-block round-robin arbitration and grant formation
  always_comb begin : arbitrate
    int unsigned idx;
    int unsigned ncont;
    logic        found;
    idx     = 0;
    ncont   = 0;
    found   = 1'b0;
    granted = '0;
    rr_d    = rr_q;
    gv_d    = '0;
    gi_d    = '0;
    gb_d    = '0;
    for (int unsigned b = 0; b < NUM_BLOCKS; b++) begin
      ncont = 0;
      found = 1'b0;
      for (int unsigned c = 0; c < NUM_CARS; c++) begin
        ncont = ncont + 32'(req[c][b]);
      end
      for (int unsigned k = 0; k < NUM_CARS; k++) begin
        idx = 32'(rr_q) + k;
        if (idx >= NUM_CARS) idx = idx - NUM_CARS;
        if (req[idx][b] && !found) begin
          found      = 1'b1;
          granted[b] = 1'b1;
          gv_d[idx]  = 1'b1;
          gi_d[idx*ITEM_WIDTH +: ITEM_WIDTH] = lfsr_q[idx*ITEM_WIDTH +: ITEM_WIDTH];
          gb_d[idx*3 +: 3] = 3'(b);
          if (ncont > 1) rr_d = (idx + 1 >= NUM_CARS) ? '0 : RRW'(idx + 1);
        end
      end
    end
  end

  // Block FSM next state: clear beats grant beats tick
  always_comb begin
    for (int unsigned b = 0; b < NUM_BLOCKS; b++) begin
      state_d[b] = state_q[b];
      cnt_d[b]   = cnt_q[b];
      if (i_clear) begin
        state_d[b] = ST_ACTIVE;
        cnt_d[b]   = '0;
      end else if (granted[b]) begin
        state_d[b] = ST_COOLDOWN;
        cnt_d[b]   = REGEN_WIDTH'(REGEN_INTERVAL);
      end else if (state_q[b] == ST_COOLDOWN && i_sec_tick) begin
        if (cnt_q[b] == REGEN_WIDTH'(1)) begin
          state_d[b] = ST_ACTIVE;
          cnt_d[b]   = '0;
        end else begin
          cnt_d[b]   = cnt_q[b] - REGEN_WIDTH'(1);
        end
      end
    end
  end

  // Block FSM state and cooldown counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned b = 0; b < NUM_BLOCKS; b++) begin
        state_q[b] <= ST_ACTIVE;
        cnt_q[b]   <= '0;
      end
    end else begin
      for (int unsigned b = 0; b < NUM_BLOCKS; b++) begin
        state_q[b] <= state_d[b];
        cnt_q[b]   <= cnt_d[b];
      end
    end
  end

  // Pipeline registers, arbitration pointer, item LFSR and grant outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v_q           <= 1'b0;
      hit_q         <= '0;
      rr_q          <= '0;
      lfsr_q        <= LFSR_SEED;
      o_grant_valid <= '0;
      o_grant_item  <= '0;
      o_grant_block <= '0;
    end else begin
      v_q           <= i_pos_valid & ~i_clear;
      hit_q         <= hit_d;
      rr_q          <= i_clear ? '0 : rr_d;
      lfsr_q        <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
      o_grant_valid <= gv_d;
      o_grant_item  <= gi_d;
      o_grant_block <= gb_d;
    end
  end

  // Visibility follows the FSM state
  always_comb begin
    for (int unsigned b = 0; b < NUM_BLOCKS; b++) begin
      o_block_active[b] = (state_q[b] == ST_ACTIVE);
    end
  end

endmodule

// File: tb/tb_qblock_manager.sv
// Self-checking bench for qblock_manager: directed scenarios plus randomized
// traffic, every cycle compared against a behavioural model.
module tb_qblock_manager;
  localparam int NB = 4, NC = 2, CW = 12, R = 24, REGEN = 10, IW = 2;

  logic clk = 1'b0;
  logic rst_n, clear, tick, pos_valid;
  logic [NC*CW-1:0] car_x, car_y;
  logic [NC-1:0]    holding;
  logic [NB-1:0]    block_active;
  logic [NC-1:0]    grant_valid;
  logic [NC*IW-1:0] grant_item;
  logic [NC*3-1:0]  grant_block;

  int bx[NB] = '{-707, -235, 688, 0};
  int by[NB] = '{0, -155, 0, -308};
  int cx[NC], cy[NC];
  int n_checks = 0, n_errors = 0;

  // behavioural model state
  bit          m_act[NB];
  int          m_cnt[NB];
  int          m_rr;
  bit          m_v1;
  bit          m_hit1[NC][NB];
  logic [15:0] m_lfsr;
  logic [NC-1:0]    e_gv;
  logic [NC*IW-1:0] e_gi;
  logic [NC*3-1:0]  e_gb;
  int          want[NC];
  bit          gblk[NB];
  int          win, ncont, new_rr;

  qblock_manager #(
    .NUM_BLOCKS(NB), .NUM_CARS(NC), .COORD_WIDTH(CW), .HIT_RADIUS(R),
    .REGEN_INTERVAL(REGEN), .REGEN_WIDTH(4), .ITEM_WIDTH(IW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_sec_tick(tick),
    .i_pos_valid(pos_valid), .i_car_x(car_x), .i_car_y(car_y),
    .i_car_holding(holding), .o_block_active(block_active),
    .o_grant_valid(grant_valid), .o_grant_item(grant_item),
    .o_grant_block(grant_block)
  );

  always #5 clk = ~clk;

  function automatic bit near(int a, int b);
    return (a - b < R) && (b - a < R);
  endfunction

  // Reference model: lowest block per car, round-robin among contenders
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NB; b++) begin m_act[b] = 1; m_cnt[b] = 0; end
      for (int c = 0; c < NC; c++) for (int b = 0; b < NB; b++) m_hit1[c][b] = 0;
      m_rr = 0; m_v1 = 0; m_lfsr = 16'hACE1;
      e_gv = '0; e_gi = '0; e_gb = '0;
    end else begin
      for (int c = 0; c < NC; c++) begin
        want[c] = -1;
        if (m_v1 && !clear && !holding[c])
          for (int b = 0; b < NB; b++)
            if (want[c] < 0 && m_hit1[c][b] && m_act[b]) want[c] = b;
      end
      e_gv = '0; e_gi = '0; e_gb = '0; new_rr = m_rr;
      for (int b = 0; b < NB; b++) begin
        gblk[b] = 0; ncont = 0; win = -1;
        for (int c = 0; c < NC; c++) if (want[c] == b) ncont++;
        for (int k = 0; k < NC; k++)
          if (win < 0 && want[(m_rr + k) % NC] == b) win = (m_rr + k) % NC;
        if (win >= 0) begin
          gblk[b] = 1;
          e_gv[win] = 1'b1;
          e_gi[win*IW +: IW] = m_lfsr[win*IW +: IW];
          e_gb[win*3 +: 3] = 3'(b);
          if (ncont > 1) new_rr = (win + 1) % NC;
        end
      end
      if (clear) begin
        for (int b = 0; b < NB; b++) begin m_act[b] = 1; m_cnt[b] = 0; end
        m_rr = 0;
      end else begin
        m_rr = new_rr;
        for (int b = 0; b < NB; b++) begin
          if (gblk[b]) begin
            m_act[b] = 0; m_cnt[b] = REGEN;
          end else if (tick && !m_act[b]) begin
            m_cnt[b]--;
            if (m_cnt[b] == 0) m_act[b] = 1;
          end
        end
      end
      m_v1 = pos_valid && !clear;
      for (int c = 0; c < NC; c++)
        for (int b = 0; b < NB; b++)
          m_hit1[c][b] = near(cx[c], bx[b]) && near(cy[c], by[b]);
      m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [NB-1:0] ea;
    for (int b = 0; b < NB; b++) ea[b] = m_act[b];
    check("active", 32'(block_active), 32'(ea));
    check("gvalid", 32'(grant_valid), 32'(e_gv));
    check("gitem",  32'(grant_item),  32'(e_gi));
    check("gblock", 32'(grant_block), 32'(e_gb));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic set_car(input int c, input int x, input int y);
    cx[c] = x; cy[c] = y;
    car_x[c*CW +: CW] = CW'(x);
    car_y[c*CW +: CW] = CW'(y);
  endtask

  task automatic far_all();
    for (int c = 0; c < NC; c++) set_car(c, 2000, 2000);
  endtask

  // request now, leaves caller at the cycle its grant is visible
  task automatic request();
    pos_valid = 1'b1; step(); pos_valid = 1'b0; step();
  endtask

  task automatic sec(input int n);
    for (int i = 0; i < n; i++) begin tick = 1'b1; step(); tick = 1'b0; step(); end
  endtask

  task automatic do_clear();
    clear = 1'b1; step(); clear = 1'b0; step();
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; tick = 1'b0; pos_valid = 1'b0; holding = '0;
    car_x = '0; car_y = '0;
    far_all();
    repeat (2) @(negedge clk);
    check("rst_active", 32'(block_active), 32'hF);
    check("rst_gvalid", 32'(grant_valid), 32'h0);
    check("rst_gblock", 32'(grant_block), 32'h0);
    rst_n = 1'b1;
    step();

    // single hit on block 0 and its respawn
    set_car(0, -700, 5);
    request();
    check("hit_gvalid", 32'(grant_valid), 32'h1);
    check("hit_gblock0", 32'(grant_block[2:0]), 32'h0);
    check("hit_active", 32'(block_active), 32'hE);
    far_all();
    sec(9);
    check("regen9", 32'(block_active), 32'hE);
    sec(1);
    check("regen10", 32'(block_active), 32'hF);

    // hit-box boundary
    set_car(0, -707 + 24, 0);
    request();
    check("edge24", 32'(grant_valid), 32'h0);
    set_car(0, -707 + 23, 0);
    request();
    check("edge23", 32'(grant_valid), 32'h1);
    far_all();
    do_clear();
    check("clear_active", 32'(block_active), 32'hF);

    // contention with rr = 0, then rr = 1
    set_car(0, 688, 0); set_car(1, 688, 0);
    request();
    check("rr0_gvalid", 32'(grant_valid), 32'h1);
    check("rr0_gblock", 32'(grant_block[2:0]), 32'h2);
    far_all();
    do_clear();
    set_car(0, 0, -308); set_car(1, 0, -308);
    request();
    check("rr_set", 32'(grant_valid), 32'h1);
    set_car(0, 688, 0); set_car(1, 688, 0);
    request();
    check("rr1_gvalid", 32'(grant_valid), 32'h2);
    check("rr1_gblock", 32'(grant_block[5:3]), 32'h2);
    far_all();
    do_clear();

    // holding mask
    holding = 2'b01;
    set_car(0, -235, -155);
    request();
    check("hold_none", 32'(grant_valid), 32'h0);
    check("hold_active", 32'(block_active), 32'hF);
    set_car(1, -235, -155);
    request();
    check("hold_car1", 32'(grant_valid), 32'h2);
    check("hold_blk", 32'(grant_block[5:3]), 32'h1);
    holding = '0;
    far_all();
    do_clear();

    // grant coincident with a tick ignores the tick
    set_car(0, 0, -308);
    pos_valid = 1'b1; step(); pos_valid = 1'b0; tick = 1'b1; step(); tick = 1'b0;
    check("tick_grant", 32'(block_active), 32'h7);
    far_all();
    sec(9);
    check("tick_regen9", 32'(block_active), 32'h7);
    sec(1);
    check("tick_regen10", 32'(block_active), 32'hF);

    // clear mid-cooldown kills an in-flight request
    set_car(0, 0, -308);
    request();
    far_all();
    sec(6);
    set_car(0, -707, 0);
    pos_valid = 1'b1; step(); pos_valid = 1'b0;
    clear = 1'b1; step(); clear = 1'b0;
    check("clr_active", 32'(block_active), 32'hF);
    check("clr_nogrant0", 32'(grant_valid), 32'h0);
    step();
    check("clr_nogrant1", 32'(grant_valid), 32'h0);

    // asynchronous reset with a grant showing
    request();
    check("pre_rst_gvalid", 32'(grant_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_active", 32'(block_active), 32'hF);
    check("arst_gvalid", 32'(grant_valid), 32'h0);
    check("arst_gitem", 32'(grant_item), 32'h0);
    check("arst_gblock", 32'(grant_block), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    far_all();
    step();

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      for (int c = 0; c < NC; c++) begin
        int sel, bsel;
        sel = int'($urandom_range(9));
        if (sel < 6) begin
          bsel = int'($urandom_range(NB - 1));
          set_car(c, bx[bsel] + int'($urandom_range(60)) - 30,
                     by[bsel] + int'($urandom_range(60)) - 30);
        end else if (sel < 8) begin
          set_car(c, ($urandom_range(1) != 0) ? 2047 : -2048,
                     ($urandom_range(1) != 0) ? 2047 : -2048);
        end else begin
          set_car(c, int'($urandom_range(4095)) - 2048, int'($urandom_range(4095)) - 2048);
        end
        holding[c] = ($urandom_range(4) == 0);
      end
      pos_valid = ($urandom_range(9) < 6);
      tick      = ($urandom_range(6) == 0);
      clear     = ($urandom_range(99) == 0);
      step();
    end
    pos_valid = 1'b0; tick = 1'b0; clear = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
